// File: rtl/microc_stack_pkg.sv
// microc_stack shared definitions: ALU operation codes and instruction
// field positions derived from the instruction/register/PC widths.
package microc_pkg;

    localparam logic [2:0] ALU_A    = 3'b000;
    localparam logic [2:0] ALU_NOTA = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_NEGA = 3'b110;
    localparam logic [2:0] ALU_NEGB = 3'b111;

    // Field LSB positions; fields may overlap by design.
    function automatic int target_lsb();
        return 0;
    endfunction

    function automatic int imm_lsb(input int ra);
        return ra;
    endfunction

    function automatic int ra1_lsb(input int ra);
        return 2 * ra;
    endfunction

    function automatic int ra2_lsb(input int ra);
        return ra;
    endfunction

    function automatic int wa3_lsb();
        return 0;
    endfunction

    function automatic int opcode_lsb(input int iw);
        return iw - 6;
    endfunction

endpackage

// File: rtl/microc_stack_if.sv
// microc_stack bus: program memory port, control strobes from the external
// control unit, and status back to it. master = control side, slave = datapath.
interface microc_stack_if #(
    parameter int PW = 10,
    parameter int IW = 16,
    parameter int SD = 8
);
    logic [PW-1:0]         imem_addr;
    logic [IW-1:0]         imem_data;
    logic                  s_abs;
    logic                  s_inc;
    logic                  s_inm;
    logic                  we3;
    logic                  wez;
    logic                  wec;
    logic [2:0]            op;
    logic                  call;
    logic                  ret;
    logic [5:0]            opcode;
    logic                  z;
    logic                  c;
    logic [$clog2(SD):0]   stk_cnt;
    logic                  stk_err;

    modport master (
        output imem_data, s_abs, s_inc, s_inm, we3, wez, wec, op, call, ret,
        input  imem_addr, opcode, z, c, stk_cnt, stk_err
    );

    modport slave (
        input  imem_data, s_abs, s_inc, s_inm, we3, wez, wec, op, call, ret,
        output imem_addr, opcode, z, c, stk_cnt, stk_err
    );
endinterface

// File: rtl/microc_stack_ret_stack.sv
// Circular return-address stack. ptr addresses the next free slot; a push
// on a full stack overwrites the oldest entry and the count saturates at SD.
module ret_stack #(
    parameter int PW = 10,
    parameter int SD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [PW-1:0]         push_data,
    output logic [PW-1:0]         tos,
    output logic [$clog2(SD):0]   cnt,
    output logic                  full,
    output logic                  empty
);
    localparam int SW = $clog2(SD);

    logic [PW-1:0] mem [SD];
    logic [SW-1:0] ptr;

    if (SD < 2 || (SD & (SD - 1)) != 0) begin : g_bad_depth
        $error("ret_stack: SD must be a power of two >= 2");
    end

    assign full  = (cnt == (SW + 1)'(SD));
    assign empty = (cnt == '0);
    assign tos   = mem[ptr - SW'(1)];

    // Pointer and occupancy; a pop on empty is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + SW'(1);
            if (!full) cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - SW'(1);
            cnt <= cnt - 1'b1;
        end
    end

    // Entry storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/microc_stack.sv
// microc_stack: single-cycle microcontroller datapath (PC, register file
// with hard-wired r0, ALU, Z/C flags, return-address stack).
// Optional macro MICROC_STACK_TRAP_EN: stack overflow/underflow jumps to
// TRAP_VEC and sets a sticky stk_err instead of wrapping / returning to 0.
module microc_stack
    import microc_pkg::*;
#(
    parameter int DW       = 8,
    parameter int PW       = 10,
    parameter int RA       = 4,
    parameter int IW       = 16,
    parameter int SD       = 8,
    parameter int TRAP_VEC = (1 << PW) - 1
) (
    input  logic        clk,
    input  logic        reset,
    microc_stack_if.slave bus
);
    localparam int NREG    = 1 << RA;
    localparam int SW      = $clog2(SD);
    localparam int TGT_LSB = target_lsb();
    localparam int IMM_LSB = imm_lsb(RA);
    localparam int RA1_LSB = ra1_lsb(RA);
    localparam int RA2_LSB = ra2_lsb(RA);
    localparam int WA3_LSB = wa3_lsb();
    localparam int OPC_LSB = opcode_lsb(IW);

    if (PW > IW - 6 || DW + RA > IW - 4 || 3 * RA > IW - 4) begin : g_bad_fields
        $error("microc_stack: instruction fields do not fit in IW");
    end
    if (TRAP_VEC < 0 || TRAP_VEC >= (1 << PW)) begin : g_bad_trap
        $error("microc_stack: TRAP_VEC outside PC range");
    end

    logic [PW-1:0] pc, pc_next, pc_seq, pc_plus1, target, tos;
    logic [DW-1:0] imm, rd1, rd2, alu_res, wd3;
    logic [RA-1:0] ra1, ra2, wa3;
    logic [DW-1:0] regs [NREG];
    logic          alu_z, alu_c;
    logic          push, pop, full, empty;
    logic [SW:0]   cnt;
    logic          z_q, c_q;
`ifdef MICROC_STACK_TRAP_EN
    logic          trap_hit;
    logic          err_q;
`endif

    assign target = bus.imem_data[TGT_LSB +: PW];
    assign imm    = bus.imem_data[IMM_LSB +: DW];
    assign ra1    = bus.imem_data[RA1_LSB +: RA];
    assign ra2    = bus.imem_data[RA2_LSB +: RA];
    assign wa3    = bus.imem_data[WA3_LSB +: RA];

    assign bus.imem_addr = pc;
    assign bus.opcode    = bus.imem_data[OPC_LSB +: 6];
    assign bus.z         = z_q;
    assign bus.c         = c_q;
    assign bus.stk_cnt   = cnt;

    // r0 is hard-wired to zero on both read ports.
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

    // ALU result and carry/borrow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (bus.op)
            ALU_A:    alu_res = rd1;
            ALU_NOTA: alu_res = ~rd1;
            ALU_ADD:  {alu_c, alu_res} = {1'b0, rd1} + {1'b0, rd2};
            ALU_SUB: begin
                alu_res = rd1 - rd2;
                alu_c   = (rd1 < rd2);
            end
            ALU_AND:  alu_res = rd1 & rd2;
            ALU_OR:   alu_res = rd1 | rd2;
            ALU_NEGA: alu_res = '0 - rd1;
            ALU_NEGB: alu_res = '0 - rd2;
            default:  alu_res = '0;
        endcase
    end

    assign alu_z    = (alu_res == '0);
    assign wd3      = bus.s_inm ? imm : alu_res;
    assign pc_plus1 = pc + PW'(1);
    assign pc_seq   = bus.s_abs ? target : pc + (bus.s_inc ? PW'(1) : target);

    // Next-PC selection and stack control: ret beats call beats sequencing.
    always_comb begin
        pc_next = pc_seq;
        push    = 1'b0;
        pop     = 1'b0;
`ifdef MICROC_STACK_TRAP_EN
        trap_hit = 1'b0;
`endif
        if (bus.ret) begin
            if (empty) begin
`ifdef MICROC_STACK_TRAP_EN
                pc_next  = PW'(TRAP_VEC);
                trap_hit = 1'b1;
`else
                pc_next  = '0;
`endif
            end else begin
                pc_next = tos;
                pop     = 1'b1;
            end
        end else if (bus.call) begin
`ifdef MICROC_STACK_TRAP_EN
            if (full) begin
                pc_next  = PW'(TRAP_VEC);
                trap_hit = 1'b1;
            end else begin
                pc_next = target;
                push    = 1'b1;
            end
`else
            pc_next = target;
            push    = 1'b1;
`endif
        end
    end

    // Program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else       pc <= pc_next;
    end

    // Register file; writes to r0 are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.we3 && wa3 != '0) begin
            regs[wa3] <= wd3;
        end
    end

    // Z and C flags, each with its own load enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            if (bus.wez) z_q <= alu_z;
            if (bus.wec) c_q <= alu_c;
        end
    end

`ifdef MICROC_STACK_TRAP_EN
    // Sticky stack-fault flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         err_q <= 1'b0;
        else if (trap_hit) err_q <= 1'b1;
    end
    assign bus.stk_err = err_q;
`else
    assign bus.stk_err = 1'b0;
`endif

    ret_stack #(
        .PW (PW),
        .SD (SD)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .tos       (tos),
        .cnt       (cnt),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_microc_stack.sv
// Testbench for microc_stack: directed scenarios plus randomized cycles,
// checked every cycle against a behavioural model (integer arithmetic,
// register array and a queue for the return stack).
module tb_microc_stack;
    localparam int DW       = 8;
    localparam int PW       = 10;
    localparam int RA       = 4;
    localparam int IW       = 16;
    localparam int SD       = 8;
    localparam int TRAP_VEC = (1 << PW) - 1;
`ifdef MICROC_STACK_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    microc_stack_if #(.PW(PW), .IW(IW), .SD(SD)) bus ();

    microc_stack #(
        .DW(DW), .PW(PW), .RA(RA), .IW(IW), .SD(SD), .TRAP_VEC(TRAP_VEC)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int m_pc;
    int m_reg [16];
    int m_z, m_c, m_err;
    int m_stk [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_z = 0; m_c = 0; m_err = 0;
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_stk.delete();
    endtask

    task automatic check_state();
        chk("pc",     32'(bus.imem_addr), 32'(m_pc));
        chk("opcode", 32'(bus.opcode),    32'(bus.imem_data) >> 10);
        chk("z",      32'(bus.z),         32'(m_z));
        chk("c",      32'(bus.c),         32'(m_c));
        chk("stk_cnt",32'(bus.stk_cnt),   32'(m_stk.size()));
        chk("stk_err",32'(bus.stk_err),   32'(m_err));
    endtask

    task automatic model_update(input int ins, input bit abs, input bit inc, input bit inm,
                                input bit we3, input bit wez, input bit wec, input int op,
                                input bit call, input bit ret);
        int a, b, wa, imm, tgt, r, cy, ret_addr;
        a   = m_reg[(ins >> 8) & 15];
        b   = m_reg[(ins >> 4) & 15];
        wa  = ins & 15;
        imm = (ins >> 4) & 255;
        tgt = ins & 1023;
        cy  = 0;
        case (op)
            0: r = a;
            1: r = 255 - a;
            2: begin r = a + b; cy = (r > 255) ? 1 : 0; end
            3: begin r = a - b; cy = (a < b) ? 1 : 0; end
            4: r = a & b;
            5: r = a | b;
            6: r = -a;
            default: r = -b;
        endcase
        r = r & 255;
        if (we3 && wa != 0) m_reg[wa] = inm ? imm : r;
        if (wez) m_z = (r == 0) ? 1 : 0;
        if (wec) m_c = cy;
        ret_addr = (m_pc + 1) % 1024;
        if (ret) begin
            if (m_stk.size() == 0) begin
                m_pc = TRAP ? TRAP_VEC : 0;
                if (TRAP) m_err = 1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (call) begin
            if (m_stk.size() == SD) begin
                if (TRAP) begin
                    m_pc = TRAP_VEC;
                    m_err = 1;
                end else begin
                    void'(m_stk.pop_front());
                    m_stk.push_back(ret_addr);
                    m_pc = tgt;
                end
            end else begin
                m_stk.push_back(ret_addr);
                m_pc = tgt;
            end
        end else if (abs) begin
            m_pc = tgt;
        end else begin
            m_pc = (m_pc + (inc ? 1 : tgt)) % 1024;
        end
    endtask

    // One clock cycle: drive at the falling edge, check before the rising
    // edge, then advance the model at the rising edge.
    task automatic cyc(input logic [15:0] ins, input bit abs, input bit inc, input bit inm,
                       input bit we3, input bit wez, input bit wec, input logic [2:0] op,
                       input bit call, input bit ret);
        bus.imem_data = ins;
        bus.s_abs = abs; bus.s_inc = inc; bus.s_inm = inm;
        bus.we3 = we3; bus.wez = wez; bus.wec = wec; bus.op = op;
        bus.call = call; bus.ret = ret;
        #2;
        check_state();
        @(posedge clk);
        model_update(int'(ins), abs, inc, inm, we3, wez, wec, int'(op), call, ret);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_data = '0; bus.s_abs = 0; bus.s_inc = 0; bus.s_inm = 0;
        bus.we3 = 0; bus.wez = 0; bus.wec = 0; bus.op = '0; bus.call = 0; bus.ret = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        reset = 1'b0;

        // Sequential fetch: 0,1,2,3
        repeat (3) idle();
        chk("seq_pc3", 32'(bus.imem_addr), 32'd3);

        // r1 <= 0xFF, r1 <= r1 + r1 with flags
        cyc({4'h0, 8'hFF, 4'h1}, 0, 1, 1, 1, 0, 0, 3'd0, 0, 0);
        cyc({4'h0, 4'h1, 4'h1, 4'h1}, 0, 1, 0, 1, 1, 1, 3'd2, 0, 0);
        #2;
        chk("add_c", 32'(bus.c), 32'd1);
        chk("add_z", 32'(bus.z), 32'd0);
        // r2 <= 0xFE; r1 - r2 must be zero
        cyc({4'h0, 8'hFE, 4'h2}, 0, 1, 1, 1, 0, 0, 3'd0, 0, 0);
        cyc({4'h0, 4'h1, 4'h2, 4'h0}, 0, 1, 0, 0, 1, 1, 3'd3, 0, 0);
        #2;
        chk("r1_is_fe", 32'(bus.z), 32'd1);

        // r0 - r0, then try to write r0 and read it back through the ALU
        cyc({4'h0, 4'h0, 4'h0, 4'h0}, 0, 1, 0, 0, 1, 1, 3'd3, 0, 0);
        cyc({4'h0, 8'h55, 4'h0}, 0, 1, 1, 1, 0, 0, 3'd0, 0, 0);
        cyc({4'h0, 4'h0, 4'h0, 4'h3}, 0, 1, 0, 0, 1, 1, 3'd0, 0, 0);
        #2;
        chk("r0_zero", 32'(bus.z), 32'd1);
        chk("sub_c",   32'(bus.c), 32'd0);

        // Jump to 0x010, call 0x100, return
        cyc(16'h0010, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
        chk("pc_010", 32'(bus.imem_addr), 32'h010);
        cyc(16'h0100, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0);
        chk("call_pc",  32'(bus.imem_addr), 32'h100);
        chk("call_cnt", 32'(bus.stk_cnt), 32'd1);
        cyc(16'h0000, 0, 1, 0, 0, 0, 0, 3'd0, 0, 1);
        chk("ret_pc",  32'(bus.imem_addr), 32'h011);
        chk("ret_cnt", 32'(bus.stk_cnt), 32'd0);

        // Nine nested calls, then eight returns
        for (int i = 0; i < 9; i++) cyc(16'h0200 + 16'(i * 8), 0, 0, 0, 0, 0, 0, 3'd0, 1, 0);
        #2;
        if (TRAP) begin
            chk("ovf_pc",  32'(bus.imem_addr), 32'h3FF);
            chk("ovf_err", 32'(bus.stk_err), 32'd1);
        end else begin
            chk("full_cnt", 32'(bus.stk_cnt), 32'd8);
        end
        for (int i = 0; i < 8; i++) cyc(16'h0000, 0, 1, 0, 0, 0, 0, 3'd0, 1, 1);
        // Return on empty stack
        cyc(16'h0000, 0, 1, 0, 0, 0, 0, 3'd0, 0, 1);
        chk("uf_pc", 32'(bus.imem_addr), TRAP ? 32'h3FF : 32'h0);

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ins;
            bit cl, rt;
            ins = 16'($urandom);
            cl  = ($urandom_range(0, 4) == 0);
            rt  = ($urandom_range(0, 5) == 0);
            cyc(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 3'($urandom), cl, rt);
        end

        // Reset in the middle of a call
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) cyc(16'h0040, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0);
        bus.call = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_pc",  32'(bus.imem_addr), 32'd0);
        chk("rst_cnt", 32'(bus.stk_cnt), 32'd0);
        @(negedge clk);
        bus.call = 1'b0;
        reset = 1'b0;
        model_reset();
        check_state();
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
